// File: rtl/regs.sv
// Integer register file x0..x31 with a hardware power-on clear sequence.
// Optional same-cycle write-through on rs1/rs2 when REGS_BYPASS_EN is defined.
module regs (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        reg_wen_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  output logic        init_done_o,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned LAST_IDX = 31;

`ifdef REGS_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic                init_done_q, init_done_d;

  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_waddr_c;
  logic [DATA_W-1:0]   mem_wdata_c;
  logic                run_we_c;

  // x0 has no storage; entries x1..x31 only.
  logic [DATA_W-1:0]   mem [1:LAST_IDX];

  // State, clear counter and done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      clr_idx_q   <= ADDR_W'(1);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      init_done_q <= init_done_d;
    end
  end

  // Next state: leave CLEAR on the edge that clears the last entry.
  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_idx_q == ADDR_W'(LAST_IDX)) begin
      state_d = RUN;
    end
  end

  // Write port steering and counter/done updates.
  always_comb begin
    clr_idx_d   = clr_idx_q;
    init_done_d = init_done_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = rd_addr_i;
    mem_wdata_c = rd_data_i;
    run_we_c    = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_idx_q;
        mem_wdata_c = '0;
        clr_idx_d   = clr_idx_q + ADDR_W'(1);
        init_done_d = (state_d == RUN);
      end
      RUN: begin
        run_we_c    = reg_wen_i && (rd_addr_i != '0);
        mem_we_c    = run_we_c;
        init_done_d = 1'b1;
      end
      default: begin
        mem_we_c = 1'b0;
      end
    endcase
  end

  // Array storage is never reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  always_comb begin
    rs1_data_o = '0;
    if (state_q == RUN && rs1_addr_i != '0) begin
      if (BYPASS && run_we_c && rd_addr_i == rs1_addr_i) begin
        rs1_data_o = rd_data_i;
      end else begin
        rs1_data_o = mem[rs1_addr_i];
      end
    end
  end

  always_comb begin
    rs2_data_o = '0;
    if (state_q == RUN && rs2_addr_i != '0) begin
      if (BYPASS && run_we_c && rd_addr_i == rs2_addr_i) begin
        rs2_data_o = rd_data_i;
      end else begin
        rs2_data_o = mem[rs2_addr_i];
      end
    end
  end

  // Debug port always shows committed contents.
  always_comb begin
    dbg_data_o = '0;
    if (state_q == RUN && dbg_addr_i != '0) begin
      dbg_data_o = mem[dbg_addr_i];
    end
  end

  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_regs.sv
// Self-checking bench for regs: clear sequence, vector table, reset mid-run,
// full write/readback and randomized traffic against an array model.
module tb_regs;

`ifdef REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, dbg_addr_i;
  logic [31:0] rs1_data_o, rs2_data_o, dbg_data_o, rd_data_i;
  logic        reg_wen_i;
  logic        init_done_o;

  regs dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_addr_i  (rs2_addr_i),
    .rs1_data_o  (rs1_data_o),
    .rs2_data_o  (rs2_data_o),
    .reg_wen_i   (reg_wen_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_i   (rd_data_i),
    .init_done_o (init_done_o),
    .dbg_addr_i  (dbg_addr_i),
    .dbg_data_o  (dbg_data_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [32];

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  ad;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected architectural read: x0 is zero, optional write-through, else stored value.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp_ok);
    if (a == 5'd0) return 32'h0;
    if (byp_ok && BYP && reg_wen_i && rd_addr_i == a) return rd_data_i;
    return model[a];
  endfunction

  // Walks the 31 clear edges after reset release, checking done timing and zero reads.
  task automatic run_clear(input string tag);
    for (int e = 1; e <= 31; e++) begin
      tick();
      check($sformatf("%s_done_e%0d", tag, e), {31'd0, init_done_o}, (e == 31) ? 32'd1 : 32'd0);
      if (e < 31) begin
        check($sformatf("%s_rs1_zero_e%0d", tag, e), rs1_data_o, 32'h0);
      end
    end
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  initial begin
    rst = 1'b0;
    reg_wen_i = 1'b0; rd_addr_i = '0; rd_data_i = '0;
    rs1_addr_i = 5'd5; rs2_addr_i = 5'd5; dbg_addr_i = 5'd5;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    vt[0] = '{1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3, 5'd3,
              BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0, 32'h0};
    vt[1] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3, 32'h12345678, 32'h12345678, 32'h12345678};
    vt[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0};
    vt[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 5'd0, 32'h0, 32'h12345678, 32'h0};
    vt[4] = '{1'b1, 5'd7, 32'h11, 5'd7, 5'd1, 5'd7, BYP ? 32'h11 : 32'h0, 32'h0, 32'h0};
    vt[5] = '{1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 5'd7, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 32'h11};
    vt[6] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd3, 5'd7, 32'h22, 32'h12345678, 32'h22};

    // Reset state.
    #12;
    check("rst_done", {31'd0, init_done_o}, 32'd0);
    check("rst_rs1", rs1_data_o, 32'h0);
    check("rst_dbg", dbg_data_o, 32'h0);

    // Release reset with a write attempt pending throughout CLEAR.
    reg_wen_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'hDEADBEEF;
    rst = 1'b1;
    #1;
    check("rel_done", {31'd0, init_done_o}, 32'd0);
    run_clear("clr1");
    reg_wen_i = 1'b0;
    #1;
    check("x5_after_clear", dbg_data_o, 32'h0);
    check("x5_rs1_after_clear", rs1_data_o, 32'h0);

    // Vector table, one clock per entry.
    for (int v = 0; v < 7; v++) begin
      reg_wen_i = vt[v].wen; rd_addr_i = vt[v].rd; rd_data_i = vt[v].wd;
      rs1_addr_i = vt[v].a1; rs2_addr_i = vt[v].a2; dbg_addr_i = vt[v].ad;
      #1;
      check($sformatf("vec%0d_rs1", v), rs1_data_o, vt[v].e1);
      check($sformatf("vec%0d_rs2", v), rs2_data_o, vt[v].e2);
      check($sformatf("vec%0d_dbg", v), dbg_data_o, vt[v].ed);
      tick();
      if (vt[v].wen && vt[v].rd != 5'd0) model[vt[v].rd] = vt[v].wd;
    end
    reg_wen_i = 1'b0;

    // Reset pulse mid-RUN.
    reg_wen_i = 1'b1; rd_addr_i = 5'd31; rd_data_i = 32'hA5A5A5A5;
    tick();
    reg_wen_i = 1'b0;
    rs1_addr_i = 5'd31; rs2_addr_i = 5'd31; dbg_addr_i = 5'd31;
    #1;
    check("x31_before_rst", rs1_data_o, 32'hA5A5A5A5);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_rs1", rs1_data_o, 32'h0);
    check("midrst_rs2", rs2_data_o, 32'h0);
    check("midrst_dbg", dbg_data_o, 32'h0);
    check("midrst_done", {31'd0, init_done_o}, 32'd0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    run_clear("clr2");
    #1;
    check("x31_after_clr2", dbg_data_o, 32'h0);
    check("x31_rs2_after_clr2", rs2_data_o, 32'h0);

    // Fill x1..x31 and read each back on the debug port.
    for (int i = 1; i < 32; i++) begin
      reg_wen_i = 1'b1; rd_addr_i = 5'(i); rd_data_i = 32'(i) * 32'h01010101;
      tick();
      model[i] = 32'(i) * 32'h01010101;
    end
    reg_wen_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr_i = 5'(i);
      #1;
      check($sformatf("fill_dbg_x%0d", i), dbg_data_o, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
    end

    // Randomized traffic against the array model.
    for (int n = 0; n < 400; n++) begin
      reg_wen_i  = 1'($urandom_range(0, 1));
      rd_addr_i  = 5'($urandom_range(0, 31));
      rd_data_i  = $urandom;
      rs1_addr_i = ($urandom_range(0, 3) == 0) ? rd_addr_i : 5'($urandom_range(0, 31));
      rs2_addr_i = ($urandom_range(0, 3) == 0) ? rd_addr_i : 5'($urandom_range(0, 31));
      dbg_addr_i = ($urandom_range(0, 3) == 0) ? rd_addr_i : 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rnd%0d_rs1", n), rs1_data_o, exp_read(rs1_addr_i, 1'b1));
      check($sformatf("rnd%0d_rs2", n), rs2_data_o, exp_read(rs2_addr_i, 1'b1));
      check($sformatf("rnd%0d_dbg", n), dbg_data_o, exp_read(dbg_addr_i, 1'b0));
      check($sformatf("rnd%0d_done", n), {31'd0, init_done_o}, 32'd1);
      tick();
      if (reg_wen_i && rd_addr_i != 5'd0) model[rd_addr_i] = rd_data_i;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regs.md
REGS -- requirements
Module: regs

Interface
REQ-001 clk  in  1  system clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, asynchronous assert, active-low.
REQ-003 rs1_addr_i  in  5  read port 1 address, driven by the decode stage.
REQ-004 rs2_addr_i  in  5  read port 2 address, driven by the decode stage.
REQ-005 rs1_data_o  out  32  read port 1 data, combinational.
REQ-006 rs2_data_o  out  32  read port 2 data, combinational.
REQ-007 reg_wen_i  in  1  write enable from the execute stage.
REQ-008 rd_addr_i  in  5  write address.
REQ-009 rd_data_i  in  32  write data.
REQ-010 init_done_o  out  1  registered; high once the register array has been fully cleared.
REQ-011 dbg_addr_i  in  5  debug read address.
REQ-012 dbg_data_o  out  32  debug read data, combinational; no bypass.

Function
REQ-013 Storage SHALL be 31 entries x 32 bits for x1..x31; x0 SHALL read as 0 on every port and SHALL ignore writes.
REQ-014 Control SHALL be a two-state FSM: CLEAR and RUN, plus a 5-bit clear counter clr_idx.
REQ-015 In CLEAR, each rising edge SHALL write 0 to entry clr_idx and then increment clr_idx.
REQ-016 CLEAR SHALL start with clr_idx=1; the edge that clears x31 SHALL move the FSM to RUN and set init_done_o=1.
REQ-017 init_done_o SHALL therefore rise exactly 31 rising edges after reset release.
REQ-018 In CLEAR, all read ports SHALL return 0 and reg_wen_i SHALL be ignored.
REQ-019 In RUN, a rising edge with reg_wen_i=1 and rd_addr_i!=0 SHALL write rd_data_i to entry rd_addr_i.
REQ-020 In RUN, a read SHALL return the stored entry, or the bypassed value defined in REQ-026.
REQ-021 rs1 and rs2 reads SHALL be independent; both ports addressing the same register SHALL return identical data.
REQ-022 Both ports SHALL be able to read in the same cycle as a write.
REQ-023 The FSM SHALL remain in RUN until the next reset; init_done_o SHALL stay 1 for that whole period.

Reset
REQ-024 Asserting rst SHALL immediately force FSM=CLEAR, clr_idx=1 and init_done_o=0, and all read outputs SHALL become 0 that same cycle.
REQ-025 Array contents are not reset directly; reset asserted mid-operation SHALL re-run the full 31-cycle clear after release, and no pre-reset value SHALL ever become visible.

Configuration
REQ-026 With macro REGS_BYPASS_EN defined, in RUN, when reg_wen_i=1, rd_addr_i!=0 and rd_addr_i equals a port's read address, that port SHALL return rd_data_i in the same cycle (write-through).
REQ-027 Without REGS_BYPASS_EN, the read SHALL return the old stored value in that cycle and the new value from the following cycle; dbg_data_o is never bypassed in either build.

Verification
REQ-028 Release reset, then count edges -> init_done_o=0 for edges 1..30 and 1 after edge 31; during CLEAR, reg_wen_i=1, rd_addr_i=5, rd_data_i=0xDEADBEEF -> x5 still reads 0 after init.
REQ-029 In RUN, write x3=0x12345678, then set rs1_addr_i=3 and rs2_addr_i=3 -> both ports return 0x12345678; write x0=0xFFFFFFFF -> x0 reads 0.
REQ-030 Hold x7=0x11 and drive a same-cycle write of x7=0x22 with rs1_addr_i=7 -> rs1_data_o=0x22 with REGS_BYPASS_EN defined, 0x11 without it; both builds read 0x22 on the next cycle.
REQ-031 Write x31=0xA5A5A5A5, pulse rst low mid-RUN -> outputs become 0 immediately, init_done_o=0; after 31 edges, x31 reads 0.
REQ-032 Write all of x1..x31 with value = index*0x01010101 and read back via dbg_addr_i -> each entry matches; dbg_addr_i=0 -> dbg_data_o=0.
